// File: rtl/dyn_latency_mem_d1.sv
// Single-port memory completing each request LATENCY cycles after acceptance with a one-cycle done pulse.
// Define DYN_MEM_JITTER_EN to add LFSR-driven latency jitter of 0..3 extra cycles.
module dyn_latency_mem_d1 #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned SIZE     = 16,
    parameter int unsigned IDX_SIZE = 4,
    parameter int unsigned LATENCY  = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [IDX_SIZE-1:0] addr0,
    input  logic                write_en,
    input  logic [WIDTH-1:0]    in,
    input  logic                read_en,
    output logic [WIDTH-1:0]    out,
    output logic                read_done,
    output logic                write_done
);

    localparam int unsigned CNT_W = $clog2(LATENCY + 4);
    localparam int unsigned AW    = (SIZE > 1) ? $clog2(SIZE) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e                state_q;
    logic [CNT_W-1:0]      cnt_q;
    logic                  wr_q;
    logic [IDX_SIZE-1:0]   addr_q;
    logic [WIDTH-1:0]      data_q;
    logic [WIDTH-1:0]      out_q;
    logic                  rd_done_q;
    logic                  wr_done_q;
    logic [WIDTH-1:0]      mem_q [SIZE];

    logic                  addr_ok_c;
    logic [AW-1:0]         idx_c;
    logic                  complete_c;
    logic [CNT_W-1:0]      load_c;

    assign addr_ok_c  = 32'(addr_q) < 32'(SIZE);
    assign idx_c      = AW'(addr_q);
    assign complete_c = (state_q == BUSY) && (cnt_q == '0);

`ifdef DYN_MEM_JITTER_EN
    logic [7:0] lfsr_q;
    logic [7:0] lfsr_next_c;

    // Fibonacci taps 8,6,5,4; jitter uses the value before the advance
    assign lfsr_next_c = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    assign load_c      = CNT_W'(LATENCY - 1) + CNT_W'(lfsr_q[1:0]);
`else
    assign load_c      = CNT_W'(LATENCY - 1);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            out_q     <= '0;
            rd_done_q <= 1'b0;
            wr_done_q <= 1'b0;
`ifdef DYN_MEM_JITTER_EN
            lfsr_q    <= 8'hA5;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (write_en || read_en) begin
                        wr_q    <= write_en;
                        addr_q  <= addr0;
                        data_q  <= in;
                        cnt_q   <= load_c;
                        state_q <= BUSY;
`ifdef DYN_MEM_JITTER_EN
                        lfsr_q  <= lfsr_next_c;
`endif
                    end
                end
                BUSY: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end else begin
                        if (wr_q) begin
                            wr_done_q <= 1'b1;
                        end else begin
                            rd_done_q <= 1'b1;
                            out_q     <= addr_ok_c ? mem_q[idx_c] : '0;
                        end
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    rd_done_q <= 1'b0;
                    wr_done_q <= 1'b0;
                    state_q   <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Array is never cleared; out-of-range writes are dropped
    always_ff @(posedge clk) begin
        if (!reset && complete_c && wr_q && addr_ok_c) begin
            mem_q[idx_c] <= data_q;
        end
    end

    assign out        = out_q;
    assign read_done  = rd_done_q;
    assign write_done = wr_done_q;

endmodule

// File: tb/tb_dyn_latency_mem_d1.sv
// Bench for dyn_latency_mem_d1: vector table, multi-cycle corner sequences and random ops vs. a model.
module tb_dyn_latency_mem_d1;

    localparam int unsigned WIDTH    = 32;
    localparam int unsigned SIZE     = 16;
    localparam int unsigned IDX_SIZE = 5;
    localparam int unsigned LATENCY  = 2;

    logic                clk;
    logic                reset;
    logic [IDX_SIZE-1:0] addr0;
    logic                write_en;
    logic [WIDTH-1:0]    in;
    logic                read_en;
    logic [WIDTH-1:0]    out;
    logic                read_done;
    logic                write_done;

    dyn_latency_mem_d1 #(
        .WIDTH   (WIDTH),
        .SIZE    (SIZE),
        .IDX_SIZE(IDX_SIZE),
        .LATENCY (LATENCY)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .addr0     (addr0),
        .write_en  (write_en),
        .in        (in),
        .read_en   (read_en),
        .out       (out),
        .read_done (read_done),
        .write_done(write_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          wr;
        bit          rd;
        logic [4:0]  addr;
        logic [31:0] data;
        bit          exp_wd;
        bit          exp_rd;
        logic [31:0] exp_out;
    } vec_t;

    vec_t        tbl[13];
    int          n_vec;
    int          n_err;
    logic [31:0] mmem[SIZE];
    logic [31:0] mout;
    logic [7:0]  lfsr_m;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected latency of the next accepted request
    task automatic next_lat(output int l);
`ifdef DYN_MEM_JITTER_EN
        l = int'(LATENCY) + int'(lfsr_m[1:0]);
        lfsr_m = {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
`else
        l = int'(LATENCY);
`endif
    endtask

    // Reference behaviour of one request
    task automatic model_op(input bit wr, input bit rd, input logic [4:0] a, input logic [31:0] d,
                            output bit ewd, output bit erd, output logic [31:0] eout);
        if (wr) begin
            if (a < 5'(SIZE)) mmem[a[3:0]] = d;
            ewd = 1'b1;
            erd = 1'b0;
        end else begin
            ewd = 1'b0;
            erd = rd;
            if (rd) mout = (a < 5'(SIZE)) ? mmem[a[3:0]] : 32'h0;
        end
        eout = mout;
    endtask

    // Issue one request from an IDLE cycle; returns observed done flags, out and latency
    task automatic do_req(input bit wr, input bit rd, input logic [4:0] a, input logic [31:0] d,
                          output bit got_wd, output bit got_rd, output logic [31:0] got_out,
                          output int lat);
        bit seen;
        write_en = wr;
        read_en  = rd;
        addr0    = a;
        in       = d;
        seen     = 1'b0;
        got_wd   = 1'b0;
        got_rd   = 1'b0;
        got_out  = 'x;
        lat      = 0;
        for (int c = 1; c <= 20 && !seen; c++) begin
            @(posedge clk); #1;
            if (write_done || read_done) begin
                seen    = 1'b1;
                got_wd  = write_done;
                got_rd  = read_done;
                got_out = out;
                lat     = c - 1;
            end
        end
        write_en = 1'b0;
        read_en  = 1'b0;
        @(posedge clk); #1;
        chk("pulse_end", {30'h0, write_done, read_done}, 32'h0);
    endtask

    task automatic run_op(input string tag, input bit wr, input bit rd, input logic [4:0] a,
                          input logic [31:0] d);
        bit          ewd, erd, gwd, grd;
        logic [31:0] eout, gout;
        int          el, gl;
        model_op(wr, rd, a, d, ewd, erd, eout);
        next_lat(el);
        do_req(wr, rd, a, d, gwd, grd, gout, gl);
        chk({tag, "_wdone"}, 32'(gwd), 32'(ewd));
        chk({tag, "_rdone"}, 32'(grd), 32'(erd));
        chk({tag, "_out"}, gout, eout);
        chk({tag, "_lat"}, 32'(gl), 32'(el));
    endtask

    initial begin
        bit          ewd, erd, gwd, grd;
        logic [31:0] eout, gout;
        int          el, gl;

        n_vec = 0; n_err = 0;
        mout = 32'h0; lfsr_m = 8'hA5;
        for (int i = 0; i < int'(SIZE); i++) mmem[i] = 32'h0;

        tbl[0]  = '{1'b1, 1'b0, 5'd3,  32'hDEADBEEF, 1'b1, 1'b0, 32'h0};
        tbl[1]  = '{1'b0, 1'b1, 5'd3,  32'h0,        1'b0, 1'b1, 32'hDEADBEEF};
        tbl[2]  = '{1'b1, 1'b0, 5'd5,  32'd7,        1'b1, 1'b0, 32'hDEADBEEF};
        tbl[3]  = '{1'b0, 1'b1, 5'd5,  32'h0,        1'b0, 1'b1, 32'd7};
        tbl[4]  = '{1'b1, 1'b0, 5'd2,  32'd4,        1'b1, 1'b0, 32'd7};
        tbl[5]  = '{1'b0, 1'b1, 5'd2,  32'h0,        1'b0, 1'b1, 32'd4};
        tbl[6]  = '{1'b1, 1'b1, 5'd2,  32'd9,        1'b1, 1'b0, 32'd4};
        tbl[7]  = '{1'b0, 1'b1, 5'd2,  32'h0,        1'b0, 1'b1, 32'd9};
        tbl[8]  = '{1'b1, 1'b0, 5'd4,  32'h44,       1'b1, 1'b0, 32'd9};
        tbl[9]  = '{1'b1, 1'b0, 5'd20, 32'hBAD,      1'b1, 1'b0, 32'd9};
        tbl[10] = '{1'b0, 1'b1, 5'd20, 32'h0,        1'b0, 1'b1, 32'h0};
        tbl[11] = '{1'b0, 1'b1, 5'd4,  32'h0,        1'b0, 1'b1, 32'h44};
        tbl[12] = '{1'b0, 1'b1, 5'd3,  32'h0,        1'b0, 1'b1, 32'hDEADBEEF};

        reset = 1'b1; write_en = 1'b0; read_en = 1'b0; addr0 = '0; in = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out", out, 32'h0);
        chk("rst_done", {30'h0, write_done, read_done}, 32'h0);
        reset = 1'b0;

        for (int i = 0; i < 13; i++) begin
            model_op(tbl[i].wr, tbl[i].rd, tbl[i].addr, tbl[i].data, ewd, erd, eout);
            next_lat(el);
            do_req(tbl[i].wr, tbl[i].rd, tbl[i].addr, tbl[i].data, gwd, grd, gout, gl);
            chk($sformatf("vec%0d_wdone", i), 32'(gwd), 32'(tbl[i].exp_wd));
            chk($sformatf("vec%0d_rdone", i), 32'(grd), 32'(tbl[i].exp_rd));
            chk($sformatf("vec%0d_out", i), gout, tbl[i].exp_out);
            chk($sformatf("vec%0d_lat", i), 32'(gl), 32'(el));
        end

`ifndef DYN_MEM_JITTER_EN
        // Held read_en: pulses every LATENCY+2 cycles, never re-accepted during DONE
        read_en = 1'b1; addr0 = 5'd5;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #1;
            chk($sformatf("held_rdone_k%0d", k), 32'(read_done), 32'((k % 4) == 3));
            chk($sformatf("held_wdone_k%0d", k), 32'(write_done), 32'h0);
            if ((k % 4) == 3) chk($sformatf("held_out_k%0d", k), out, 32'd7);
        end
        read_en = 1'b0;
        mout = 32'd7;
        @(posedge clk); #1;
`endif

        // Reset one cycle after accepting a write aborts it and clears out
        run_op("pre_w1", 1'b1, 1'b0, 5'd1, 32'h11);
        run_op("pre_r3", 1'b0, 1'b1, 5'd3, 32'h0);
        write_en = 1'b1; addr0 = 5'd1; in = 32'h55;
        @(posedge clk); #1;
        write_en = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        mout = 32'h0; lfsr_m = 8'hA5;
        chk("rst_mid_out", out, 32'h0);
        chk("rst_mid_done", {30'h0, write_done, read_done}, 32'h0);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            chk($sformatf("rst_mid_quiet%0d", k), {30'h0, write_done, read_done}, 32'h0);
        end
        run_op("post_rst_r1", 1'b0, 1'b1, 5'd1, 32'h0);

        for (int i = 0; i < int'(SIZE); i++) run_op($sformatf("init%0d", i), 1'b1, 1'b0, 5'(i), $urandom);
        for (int i = 0; i < 40; i++) begin
            int unsigned r;
            r = $urandom_range(0, 3);
            run_op($sformatf("rnd%0d", i), (r <= 1), (r != 1), 5'($urandom_range(0, 23)), $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dyn_latency_mem_d1.md
Name: dyn_latency_mem_d1

Overview:
- Single-port, one-dimensional memory that serves the request side of the dynamic-latency memory handshake: read_en/write_en with addr0 in, read_done/write_done with out back.
- Sits behind a port arbiter or a Calyx component and models a variable-latency backing store.
- Completes each request LATENCY cycles after acceptance, with a one-cycle done pulse.

Parameters:
- WIDTH, 32, data word width in bits.
- SIZE, 16, number of words.
- IDX_SIZE, 4, address width in bits.
- LATENCY, 2, cycles from acceptance to done pulse; must be >= 1.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous active-high reset.
- addr0  input  IDX_SIZE  word address; held stable by requester until done.
- write_en  input  1  write request; level, held until write_done.
- in  input  WIDTH  write data; held stable until write_done.
- read_en  input  1  read request; level, held until read_done.
- out  output  WIDTH  read data register; updated only on read completion.
- read_done  output  1  one-cycle read completion pulse.
- write_done  output  1  one-cycle write completion pulse.

Behaviour:
- One clock, clk. Reset is synchronous and active-high on reset, sampled on the rising edge of clk.
- Reset values: out=0, read_done=0, write_done=0, state=IDLE, counter=0.
- The memory array is not cleared by reset.
- States:
  - IDLE: at an edge with write_en|read_en=1, latch op (write wins if both high), addr0 and in into request registers, load counter=LATENCY-1, go to BUSY.
  - BUSY: ignore all inputs and use only the latched values. If counter!=0, decrement. If counter==0, complete: on a write, mem[addr] <= in_latched and write_done <= 1; on a read, out <= mem[addr] and read_done <= 1; go to DONE.
  - DONE: the done pulse is visible for exactly this cycle. Inputs are ignored (the requester may still hold its enable). Clear the done flags and go to IDLE.
- Timing: request high in cycle 0 gives done high in cycle LATENCY+1 (LATENCY=1: cycle 2). The earliest next acceptance is at the end of cycle LATENCY+2.
- Only one outstanding request; no pipelining.
- read_en and write_en both high at acceptance: performs the write only. write_done pulses, read_done stays 0, out is unchanged.
- Address out of range (addr >= SIZE): a write is dropped, but write_done still pulses. A read returns 0 in out, and read_done pulses.
- out holds its value across writes and idle cycles until the next read completes.
- Reset asserted mid-operation: the request is aborted, there is no done pulse, no array write occurs, and out is cleared to 0.
- read_done and write_done are never high in the same cycle.
- An enable dropped before done does not cancel the request; it still completes.

Optional Feature:
- Macro: DYN_MEM_JITTER_EN.
- Defined:
  - Adds an 8-bit Fibonacci LFSR (taps 8,6,5,4) reset to 8'hA5.
  - The LFSR advances once per accepted request.
  - The counter loads LATENCY-1+lfsr[1:0], sampled before the advance, so latency varies over LATENCY..LATENCY+3 with a deterministic sequence.
- Undefined: no LFSR logic; latency is fixed at LATENCY.

Test Plan:
- Write then read, LATENCY=2: addr0=3, in=32'hDEADBEEF, write_en held → write_done pulses in cycle 3 only. Then read_en at addr0=3 → read_done one cycle, out=32'hDEADBEEF.
- Held enable: keep read_en=1 continuously at addr0=5 (mem[5]=7) → read_done pulses 1 cycle, no re-accept during DONE, next accept one cycle later. Done pulses are LATENCY+2 cycles apart, out=7 throughout.
- Both enables: write_en=read_en=1, addr0=2, in=9, previous out=4 → write_done only, mem[2]=9, out stays 4.
- Out of range: addr0=20 with SIZE=16 → write_done pulses and no word is modified. A read at addr0=20 → read_done, out=0.
- Reset mid-op: assert reset one cycle after acceptance of a write of 8'h55 to addr0=1 (mem[1] previously 0x11) → no write_done, mem[1]=0x11, out=0, state IDLE.
- DYN_MEM_JITTER_EN defined, LATENCY=1: four back-to-back reads → done latencies match the LFSR sequence from seed 8'hA5, each within 1..4, out correct for each.
